// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU cluster: IEEE-754 single field layout,
// special-value encodings, fixed-point saturation limits and the state type.
package fpu_pkg;

   localparam int SIGN_BIT = 31;
   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;
   localparam int EXP_BIAS = 127;

   localparam logic [EXP_W-1:0] EXP_ONES = 8'hFF;

   localparam logic [31:0] CANON_NAN   = 32'h7FC0_0000;
   localparam logic [31:0] FIX_POS_SAT = 32'h7FFF_FFFF;
   localparam logic [31:0] FIX_NEG_SAT = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SPECIAL = 3'd1,
      ST_CONVERT = 3'd2,
      ST_SIGN    = 3'd3,
      ST_DONE    = 3'd4
   } fpu_state_e;

   // Saturation value for an out-of-range operand of the given sign.
   function automatic logic [31:0] fix_sat(input logic sign);
      return sign ? FIX_NEG_SAT : FIX_POS_SAT;
   endfunction

endpackage

// File: rtl/float_to_fixed.sv
// Iterative IEEE-754 single to signed 32-bit fixed-point converter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for exec_strobe_i; operand captured on acceptance
// ST_SPECIAL | classify operand; resolve NaN/inf/zero/underflow/saturate
// ST_CONVERT | shift magnitude right one bit per cycle until count is 0
// ST_SIGN    | apply sign, register result, raise done
// ST_DONE    | done pulse visible this cycle; return to idle
//
// Result is trunc(value * 2^FRAC_BITS); bits shifted out are dropped, so
// rounding is toward zero for both signs.
module float_to_fixed
   import fpu_pkg::*;
#(
   parameter int FRAC_BITS = 0
) (
   input  logic        clk,
   input  logic        reset_ni,
   input  logic [31:0] a_value_i,
   input  logic        exec_strobe_i,
   output logic [31:0] z_value_o,
   output logic        done_strobe_o
);

   fpu_state_e  state_q, state_d;
   logic [31:0] operand_q, operand_d;
   logic [31:0] mag_q, mag_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] z_q, z_d;
   logic        done_q, done_d;

   logic              op_sign;
   logic [EXP_W-1:0]  op_exp;
   logic [FRAC_W-1:0] op_frac;
   logic signed [9:0] exp_eff;

   assign op_sign = operand_q[SIGN_BIT];
   assign op_exp  = operand_q[FRAC_W +: EXP_W];
   assign op_frac = operand_q[FRAC_W-1:0];

   // Unbiased exponent plus fractional-bit offset; range fits easily in 10 bits.
   assign exp_eff = signed'({2'b00, op_exp})
                  - signed'(10'(EXP_BIAS))
                  + signed'(10'(FRAC_BITS));

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_ni) begin
         state_q   <= ST_IDLE;
         operand_q <= '0;
         mag_q     <= '0;
         cnt_q     <= '0;
         z_q       <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         operand_q <= operand_d;
         mag_q     <= mag_d;
         cnt_q     <= cnt_d;
         z_q       <= z_d;
         done_q    <= done_d;
      end
   end

   // Next-state and datapath update; every register holds unless written.
   always_comb begin
      state_d   = state_q;
      operand_d = operand_q;
      mag_d     = mag_q;
      cnt_d     = cnt_q;
      z_d       = z_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (exec_strobe_i) begin
               operand_d = a_value_i;
               state_d   = ST_SPECIAL;
            end
         end

         ST_SPECIAL: begin
            done_d  = 1'b1;
            state_d = ST_DONE;
            if (op_exp == EXP_ONES) begin
               // NaN maps to the negative limit regardless of its sign bit.
               z_d = (op_frac != '0) ? FIX_NEG_SAT : fix_sat(op_sign);
            end else if (op_exp == '0) begin
               z_d = '0;
            end else if (exp_eff < 10'sd0) begin
               z_d = '0;
            end else if (exp_eff >= 10'sd31) begin
               // Exact -2^31 lands here and FIX_NEG_SAT is its true value.
               z_d = fix_sat(op_sign);
            end else begin
               done_d  = 1'b0;
               mag_d   = {1'b1, op_frac, 8'b0};
               cnt_d   = 5'd31 - exp_eff[4:0];
               state_d = ST_CONVERT;
            end
         end

         ST_CONVERT: begin
            if (cnt_q != '0) begin
               mag_d = mag_q >> 1;
               cnt_d = cnt_q - 5'd1;
            end else begin
               state_d = ST_SIGN;
            end
         end

         ST_SIGN: begin
            // Magnitude is at most 2^31-1 here, so negation cannot overflow.
            z_d     = op_sign ? (32'd0 - mag_q) : mag_q;
            done_d  = 1'b1;
            state_d = ST_DONE;
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign z_value_o     = z_q;
   assign done_strobe_o = done_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed bench for float_to_fixed: one instance with FRAC_BITS=0 and one
// with FRAC_BITS=16, sharing clock, reset and operand bus.
module tb_float_to_fixed;

   logic        clk;
   logic        reset_ni;
   logic [31:0] a_value;
   logic        exec0, exec16;
   logic [31:0] z0, z16;
   logic        done0, done16;

   int total;
   int bad;

   float_to_fixed #(.FRAC_BITS(0)) dut0 (
      .clk           (clk),
      .reset_ni      (reset_ni),
      .a_value_i     (a_value),
      .exec_strobe_i (exec0),
      .z_value_o     (z0),
      .done_strobe_o (done0)
   );

   float_to_fixed #(.FRAC_BITS(16)) dut16 (
      .clk           (clk),
      .reset_ni      (reset_ni),
      .a_value_i     (a_value),
      .exec_strobe_i (exec16),
      .z_value_o     (z16),
      .done_strobe_o (done16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a strobe in the current cycle (cycle 0); returns in cycle 1.
   task automatic start(input bit sel, input logic [31:0] val);
      a_value = val;
      if (sel) exec16 = 1'b1;
      else     exec0  = 1'b1;
      step();
      exec0  = 1'b0;
      exec16 = 1'b0;
      a_value = $urandom;
   endtask

   // Wait for done, check its cycle number and the result, then check that
   // done drops the following cycle. A nonzero glitch_at re-strobes the busy
   // unit with a NaN operand in that cycle. Returns in the cycle after done.
   task automatic wait_done(input bit sel, input string tag, input logic [31:0] exp_z,
                            input int exp_cyc, input int glitch_at);
      int seen;
      logic d;
      seen = 0;
      for (int n = 1; n <= 60; n++) begin
         d = sel ? done16 : done0;
         if (d) begin
            seen = n;
            break;
         end
         if (n == glitch_at) begin
            a_value = 32'h7FC0_0000;
            if (sel) exec16 = 1'b1;
            else     exec0  = 1'b1;
         end
         step();
         exec0  = 1'b0;
         exec16 = 1'b0;
      end
      check({tag, "_cyc"}, 32'(seen), 32'(exp_cyc));
      check({tag, "_z"}, sel ? z16 : z0, exp_z);
      step();
      check({tag, "_pulse"}, 32'(sel ? done16 : done0), 32'd0);
   endtask

   initial begin
      int late_done;
      total    = 0;
      bad      = 0;
      reset_ni = 1'b0;
      a_value  = '0;
      exec0    = 1'b0;
      exec16   = 1'b0;
      repeat (3) step();
      check("rst_z0", z0, 32'h0);
      check("rst_done0", 32'(done0), 32'h0);
      check("rst_z16", z16, 32'h0);
      reset_ni = 1'b1;
      step();

      // Normal path, FRAC_BITS=0; the second and third are back-to-back.
      start(1'b0, 32'h3F80_0000);
      wait_done(1'b0, "one", 32'h0000_0001, 35, 0);
      start(1'b0, 32'h4020_0000);
      wait_done(1'b0, "p2_5", 32'h0000_0002, 34, 0);
      start(1'b0, 32'hC020_0000);
      wait_done(1'b0, "m2_5", 32'hFFFF_FFFE, 34, 0);

      // Normal path, FRAC_BITS=16: c = 15 and 17.
      start(1'b1, 32'h3FC0_0000);
      wait_done(1'b1, "f16_1_5", 32'h0001_8000, 19, 0);
      start(1'b1, 32'h3E80_0000);
      wait_done(1'b1, "f16_0_25", 32'h0000_4000, 21, 0);

      // Special and saturated cases, all done in cycle 2.
      start(1'b0, 32'h7FC0_0000);
      wait_done(1'b0, "nan", 32'h8000_0000, 2, 0);
      start(1'b0, 32'h4F32_D05E);
      wait_done(1'b0, "big_pos", 32'h7FFF_FFFF, 2, 0);
      start(1'b0, 32'hCF00_0000);
      wait_done(1'b0, "min_int", 32'h8000_0000, 2, 0);
      start(1'b0, 32'h7F80_0000);
      wait_done(1'b0, "pinf", 32'h7FFF_FFFF, 2, 0);
      start(1'b0, 32'hFF80_0000);
      wait_done(1'b0, "minf", 32'h8000_0000, 2, 0);
      start(1'b0, 32'h3E80_0000);
      wait_done(1'b0, "underflow", 32'h0000_0000, 2, 0);
      start(1'b0, 32'h4020_0000);
      wait_done(1'b0, "reload", 32'h0000_0002, 34, 0);
      start(1'b0, 32'h0000_0001);
      wait_done(1'b0, "denorm", 32'h0000_0000, 2, 0);

      // Largest non-saturating exponent: 1.5 * 2^30.
      start(1'b0, 32'h4EC0_0000);
      wait_done(1'b0, "e30", 32'h6000_0000, 5, 0);

      // Strobe during CONVERT is ignored.
      start(1'b0, 32'hC020_0000);
      wait_done(1'b0, "glitch", 32'hFFFF_FFFE, 34, 6);
      check("glitch_idle", 32'(done0), 32'h0);

      // Reset mid-CONVERT aborts and clears.
      start(1'b0, 32'h3F80_0000);
      repeat (9) step();
      reset_ni = 1'b0;
      step();
      reset_ni = 1'b1;
      check("abort_z", z0, 32'h0);
      check("abort_done", 32'(done0), 32'h0);
      late_done = 0;
      for (int n = 0; n < 40; n++) begin
         if (done0) late_done = 1;
         step();
      end
      check("abort_no_done", 32'(late_done), 32'h0);

      // Unit is idle again and accepts immediately.
      start(1'b0, 32'hC020_0000);
      wait_done(1'b0, "post_rst", 32'hFFFF_FFFE, 34, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
